// File: rtl/irq_controller.sv
// irq_controller: memory-mapped interrupt aggregator.
//   Latches per-source events into PENDING (level or rising-edge mode per
//   source), masks them with ENABLE and drives one registered irq line.
//   VECTOR reports the lowest-index enabled pending source.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   select       - bus select; rdata is 0 when deasserted
//   addr         - word address (0 RAW, 1 PENDING, 2 ENABLE, 3 EDGE, 4 VECTOR)
//   we, wdata    - byte-lane write enables and write data
//   rdata        - combinational read data
//   src          - interrupt sources, synchronous to clk, active high
//   irq          - registered interrupt request

// Per-source state: input delay, pending, enable and edge-mode bits.
module irq_src_cell #(
    parameter logic EDGE_INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic src,
    input  logic wbit,       // write data bit for this source
    input  logic en_wr,      // ENABLE write strobe (lane qualified)
    input  logic edge_wr,    // EDGE write strobe (lane qualified)
    input  logic clr_wr,     // PENDING write strobe (lane qualified)
    output logic pending,
    output logic enable,
    output logic edge_mode
);
    logic src_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_d     <= 1'b0;
            pending   <= 1'b0;
            enable    <= 1'b0;
            edge_mode <= EDGE_INIT;
        end else begin
            src_d <= src;
            if (en_wr)   enable    <= wbit;
            if (edge_wr) edge_mode <= wbit;
            // Mode in effect is the pre-write value, so a mode change
            // only alters pending behaviour from the following edge.
            if (!edge_mode)
                pending <= src;
            else if (src && !src_d)
                pending <= 1'b1;          // a new rise beats a same-cycle clear
            else if (clr_wr && wbit)
                pending <= 1'b0;
        end
    end
endmodule

module irq_controller #(
    parameter int          NSRC       = 8,
    parameter logic [31:0] EDGE_RESET = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            select,
    input  logic [2:0]      addr,
    input  logic [3:0]      we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src,
    output logic            irq
);
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] edge_mode;
    logic [NSRC-1:0] active;
    logic            sel_pend;
    logic            sel_en;
    logic            sel_edge;

    assign sel_pend = select && (addr == 3'd1);
    assign sel_en   = select && (addr == 3'd2);
    assign sel_edge = select && (addr == 3'd3);

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        irq_src_cell #(.EDGE_INIT(EDGE_RESET[i])) u_cell (
            .clk       (clk),
            .reset     (reset),
            .src       (src[i]),
            .wbit      (wdata[i]),
            .en_wr     (sel_en   && we[i/8]),
            .edge_wr   (sel_edge && we[i/8]),
            .clr_wr    (sel_pend && we[i/8]),
            .pending   (pending[i]),
            .enable    (enable[i]),
            .edge_mode (edge_mode[i])
        );
    end

    assign active = pending & enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq <= 1'b0;
        else       irq <= |active;
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    logic       vec_valid;
    logic [4:0] vec_idx;
    always_comb begin
        vec_valid = 1'b0;
        vec_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_valid = 1'b1;
                vec_idx   = 5'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (select) begin
            case (addr)
                3'd0:    rdata = 32'(src);
                3'd1:    rdata = 32'(pending);
                3'd2:    rdata = 32'(enable);
                3'd3:    rdata = 32'(edge_mode);
                3'd4:    rdata = vec_valid ? {1'b1, 26'd0, vec_idx} : 32'd0;
                default: rdata = '0;
            endcase
        end
    end
endmodule
